// File: rtl/wb_ddr_arbiter.sv
// Three-master round-robin Wishbone arbiter in front of the single DDR controller slave port.
// Optional watchdog abort enabled by defining WB_ARB_TIMEOUT_EN.
module wb_ddr_arbiter #(
  parameter int unsigned adr_width = 32,
  parameter int unsigned timeout   = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [3:0]           m0_sel_i,
  input  logic [31:0]          m0_dat_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [3:0]           m1_sel_i,
  input  logic [31:0]          m1_dat_i,
  output logic [31:0]          m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  input  logic                 m2_cyc_i,
  input  logic                 m2_stb_i,
  input  logic                 m2_we_i,
  input  logic [adr_width-1:0] m2_adr_i,
  input  logic [3:0]           m2_sel_i,
  input  logic [31:0]          m2_dat_i,
  output logic [31:0]          m2_dat_o,
  output logic                 m2_ack_o,
  output logic                 m2_err_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [adr_width-1:0] s_adr_o,
  output logic [3:0]           s_sel_o,
  output logic [31:0]          s_dat_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,
  output logic [1:0]           gnt_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_n;
  logic [1:0]           gnt, gnt_n, last, last_n;
  logic [2:0]           req;
  logic [1:0]           pick, cand;
  logic                 found;
  logic                 abort;

  logic                 gcyc, gstb, gwe;
  logic [adr_width-1:0] gadr;
  logic [3:0]           gsel;
  logic [31:0]          gdat;

  assign req = {m2_cyc_i, m1_cyc_i, m0_cyc_i};

  // Search starts just after the last granted master, so every requester gets a turn.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= 3; i++) begin
      cand = 2'((32'(last) + i) % 32'd3);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gcyc = 1'b0;
    gstb = 1'b0;
    gwe  = 1'b0;
    gadr = '0;
    gsel = '0;
    gdat = '0;
    case (gnt)
      2'd0: begin
        gcyc = m0_cyc_i; gstb = m0_stb_i; gwe = m0_we_i;
        gadr = m0_adr_i; gsel = m0_sel_i; gdat = m0_dat_i;
      end
      2'd1: begin
        gcyc = m1_cyc_i; gstb = m1_stb_i; gwe = m1_we_i;
        gadr = m1_adr_i; gsel = m1_sel_i; gdat = m1_dat_i;
      end
      2'd2: begin
        gcyc = m2_cyc_i; gstb = m2_stb_i; gwe = m2_we_i;
        gadr = m2_adr_i; gsel = m2_sel_i; gdat = m2_dat_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = pick;
          last_n  = pick;
        end
      end
      GRANT: begin
        if (!gcyc || abort) begin
          state_n = IDLE;
          gnt_n   = 2'd3;
          last_n  = gnt;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 2'd3;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 2'd3;
      last  <= 2'd2;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      last  <= last_n;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(timeout + 2);
  logic [CW-1:0] count;

  assign abort = (state == GRANT) && (count == CW'(timeout));

  always_ff @(posedge clk) begin
    if (reset || state_n != GRANT || s_ack_i)
      count <= '0;
    else if (s_stb_o)
      count <= count + CW'(1);
  end

  assign m0_err_o = abort && (gnt == 2'd0);
  assign m1_err_o = abort && (gnt == 2'd1);
  assign m2_err_o = abort && (gnt == 2'd2);
`else
  assign abort    = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
  assign m2_err_o = 1'b0;
`endif

  // gnt is 3 outside GRANT, so the mux alone keeps the slave idle and stray acks unrouted.
  assign s_cyc_o  = gcyc & ~abort;
  assign s_stb_o  = gstb & ~abort;
  assign s_we_o   = gwe;
  assign s_adr_o  = gadr;
  assign s_sel_o  = gsel;
  assign s_dat_o  = gdat;

  assign m0_ack_o = s_ack_i & ~abort & (gnt == 2'd0);
  assign m1_ack_o = s_ack_i & ~abort & (gnt == 2'd1);
  assign m2_ack_o = s_ack_i & ~abort & (gnt == 2'd2);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m2_dat_o = s_dat_i;

  assign gnt_o    = gnt;

endmodule

// File: tb/tb_wb_ddr_arbiter.sv
// Self-checking bench for wb_ddr_arbiter: directed scenarios plus randomized traffic
// against a transaction-level rotation model.
module tb_wb_ddr_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       cyc, stb, we;
  logic [2:0][31:0] adr, dat, mdat;
  logic [2:0][3:0]  sel;
  logic [2:0]       ack, err;
  logic             s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [31:0]      s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]       s_sel_o;
  logic [1:0]       gnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_ddr_arbiter #(.adr_width(32), .timeout(15)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
    .m0_sel_i(sel[0]), .m0_dat_i(dat[0]), .m0_dat_o(mdat[0]), .m0_ack_o(ack[0]), .m0_err_o(err[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
    .m1_sel_i(sel[1]), .m1_dat_i(dat[1]), .m1_dat_o(mdat[1]), .m1_ack_o(ack[1]), .m1_err_o(err[1]),
    .m2_cyc_i(cyc[2]), .m2_stb_i(stb[2]), .m2_we_i(we[2]), .m2_adr_i(adr[2]),
    .m2_sel_i(sel[2]), .m2_dat_i(dat[2]), .m2_dat_o(mdat[2]), .m2_ack_o(ack[2]), .m2_err_o(err[2]),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  task automatic clear_inputs();
    cyc = '0; stb = '0; we = '0; adr = '0; dat = '0; sel = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
  endtask

  // Leaves the bench just after the first edge with reset low pending.
  task automatic do_reset(input int n);
    reset = 1'b1;
    clear_inputs();
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(4);
    @(negedge clk);
    checks++; if (gnt_o !== 2'd3) begin errors++; $display("FAIL reset_gnt: got %0d expected 3", gnt_o); end
    checks++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin errors++; $display("FAIL reset_cyc_stb: got %b expected 00", {s_cyc_o, s_stb_o}); end
    checks++; if ({ack, err} !== 6'b0) begin errors++; $display("FAIL reset_ack_err: got %b expected 000000", {ack, err}); end
  endtask

  task automatic test_single_write();
    int stb_c = -1, ack_c = -1, acks = 0, other = 0;
    logic acked;
    do_reset(2);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
    adr[1] = 32'h4000_0010; dat[1] = 32'hCAFE_BABE;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (s_stb_o && stb_c < 0) begin
        stb_c = c;
        checks++; if ({s_we_o, s_adr_o, s_sel_o, s_dat_o} !== {1'b1, 32'h4000_0010, 4'hF, 32'hCAFE_BABE}) begin
          errors++; $display("FAIL write_bus: got we=%b adr=%h sel=%h dat=%h expected 1 40000010 f cafebabe", s_we_o, s_adr_o, s_sel_o, s_dat_o);
        end
        checks++; if (gnt_o !== 2'd1) begin errors++; $display("FAIL write_gnt: got %0d expected 1", gnt_o); end
      end
      acked = ack[1];
      if (acked) begin acks++; ack_c = c; end
      if (ack[0] || ack[2]) other++;
      @(posedge clk); #1;
      s_ack_i = (stb_c >= 0) && (c + 1 == stb_c + 3);
      if (acked) begin cyc[1] = 1'b0; stb[1] = 1'b0; end
    end
    @(negedge clk);
    checks++; if (stb_c !== 1) begin errors++; $display("FAIL write_arb_latency: got %0d expected 1", stb_c); end
    checks++; if (acks !== 1 || ack_c !== 4) begin errors++; $display("FAIL write_ack: got count=%0d cycle=%0d expected count=1 cycle=4", acks, ack_c); end
    checks++; if (other !== 0) begin errors++; $display("FAIL write_other_ack: got %0d expected 0", other); end
    checks++; if (gnt_o !== 2'd3) begin errors++; $display("FAIL write_gnt_release: got %0d expected 3", gnt_o); end
  endtask

  task automatic test_simultaneous();
    int order[$];
    int acks[3] = '{0, 0, 0};
    logic [2:0] got;
    logic ack_now;
    do_reset(2);
    for (int n = 0; n < 3; n++) adr[n] = $urandom;
    cyc = 3'b111; stb = 3'b111;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (gnt_o != 2'd3 && (order.size() == 0 || order[order.size()-1] != int'(gnt_o))) order.push_back(int'(gnt_o));
      if (s_stb_o && gnt_o != 2'd3) begin
        checks++; if (s_adr_o !== adr[gnt_o]) begin errors++; $display("FAIL simul_adr: got %h expected %h", s_adr_o, adr[gnt_o]); end
      end
      got = ack;
      for (int n = 0; n < 3; n++) begin
        if (got[n]) begin
          acks[n]++;
          checks++; if (mdat[n] !== s_dat_i) begin errors++; $display("FAIL simul_rdata_m%0d: got %h expected %h", n, mdat[n], s_dat_i); end
        end
      end
      ack_now = s_stb_o && !s_ack_i;
      @(posedge clk); #1;
      cyc = cyc & ~got; stb = stb & ~got;
      s_ack_i = ack_now;
      s_dat_i = $urandom;
    end
    checks++; if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
      errors++; $display("FAIL simul_order: got %p expected '{0, 1, 2}", order);
    end
    checks++; if (acks[0] != 1 || acks[1] != 1 || acks[2] != 1) begin
      errors++; $display("FAIL simul_acks: got %0d/%0d/%0d expected 1/1/1", acks[0], acks[1], acks[2]);
    end
  endtask

  task automatic test_burst();
    int beats = 4, m1_acks = 0, m0_acks = 0, drop_c = -1, g0_c = -1;
    logic [1:0] gnt_after_drop = 2'd0;
    logic stb_seen = 1'b0, acked;
    do_reset(2);
    cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h0000_1000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acked = ack[1];
      if (acked) m1_acks++;
      if (ack[0]) m0_acks++;
      if (drop_c < 0 && gnt_o == 2'd1 && !cyc[1]) drop_c = c;
      if (drop_c >= 0 && c == drop_c + 1) gnt_after_drop = gnt_o;
      if (g0_c < 0 && gnt_o == 2'd0) g0_c = c;
      stb_seen = (gnt_o == 2'd1) && s_stb_o;
      @(posedge clk); #1;
      if (c == 0) begin cyc[0] = 1'b1; stb[0] = 1'b1; end
      if (acked) begin
        beats--;
        adr[1] = adr[1] + 32'd4;
        if (beats == 0) begin cyc[1] = 1'b0; stb[1] = 1'b0; end
      end
      s_ack_i = stb_seen && stb[1];
    end
    checks++; if (m1_acks !== 4) begin errors++; $display("FAIL burst_m1_acks: got %0d expected 4", m1_acks); end
    checks++; if (m0_acks !== 0) begin errors++; $display("FAIL burst_m0_ack: got %0d expected 0", m0_acks); end
    checks++; if (gnt_after_drop !== 2'd3) begin errors++; $display("FAIL burst_arb_gap: got %0d expected 3", gnt_after_drop); end
    checks++; if (drop_c < 0 || g0_c !== drop_c + 2) begin errors++; $display("FAIL burst_m0_grant: got cycle %0d expected %0d", g0_c, drop_c + 2); end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    do_reset(2);
    cyc[2] = 1'b1; stb[2] = 1'b1; adr[2] = $urandom;
    @(negedge clk);
    while (gnt_o != 2'd2 && waited < 10) begin waited++; @(negedge clk); end
    checks++; if (gnt_o !== 2'd2 || s_stb_o !== 1'b1) begin errors++; $display("FAIL rstmid_grant: got gnt=%0d stb=%b expected gnt=2 stb=1", gnt_o, s_stb_o); end
    @(posedge clk); #1;
    reset = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk); #1;
    s_ack_i = 1'b1;
    @(negedge clk);
    checks++; if ({s_cyc_o, s_stb_o, gnt_o} !== 4'b0011) begin errors++; $display("FAIL rstmid_idle: got cyc=%b stb=%b gnt=%0d expected 0 0 3", s_cyc_o, s_stb_o, gnt_o); end
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL rstmid_ack: got %b expected 000", ack); end
    @(posedge clk); #1;
    reset = 1'b0; s_ack_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (gnt_o !== 2'd0) begin errors++; $display("FAIL rstmid_priority: got %0d expected 0", gnt_o); end
  endtask

  task automatic test_timeout();
    int k = 0, err1 = 0, err1_k = -1, err_any = 0, not_m1 = 0;
    logic prev_err = 1'b0, cyc_after = 1'b1, got2 = 1'b0;
    do_reset(2);
    cyc = 3'b110; stb = 3'b110; adr[1] = 32'h0000_0200; adr[2] = 32'h0000_0300;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (gnt_o == 2'd1) k++;
      if (c > 0 && gnt_o != 2'd1) not_m1++;
      if (prev_err) cyc_after = s_cyc_o;
      prev_err = err[1];
      if (err[1]) begin err1++; if (err1_k < 0) err1_k = k; end
      if (err != 3'b000) err_any++;
      if (gnt_o == 2'd2) got2 = 1'b1;
      @(posedge clk); #1;
    end
`ifdef WB_ARB_TIMEOUT_EN
    checks++; if (err1 !== 1 || err1_k !== 16) begin errors++; $display("FAIL timeout_err: got count=%0d at stb cycle %0d expected 1 at 16", err1, err1_k); end
    checks++; if (cyc_after !== 1'b0) begin errors++; $display("FAIL timeout_cyc_drop: got %b expected 0", cyc_after); end
    checks++; if (got2 !== 1'b1) begin errors++; $display("FAIL timeout_m2_grant: got %b expected 1", got2); end
`else
    checks++; if (err_any !== 0) begin errors++; $display("FAIL notimeout_err: got %0d expected 0", err_any); end
    checks++; if (not_m1 !== 0 || k !== 29) begin errors++; $display("FAIL notimeout_hold: got %0d other-grant cycles, %0d m1 cycles expected 0, 29", not_m1, k); end
`endif
  endtask

  task automatic test_random();
    int exp_gnt = 3, exp_last = 2, nxt_gnt, nxt_last, lat = 0, g;
    int beats[3] = '{0, 0, 0};
    logic [2:0] exp_ack, acked;
    logic [70:0] exp_bus;
    do_reset(2);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      exp_ack = '0;
      checks++; if (int'(gnt_o) != exp_gnt) begin errors++; $display("FAIL rand_gnt c%0d: got %0d expected %0d", c, gnt_o, exp_gnt); end
      if (exp_gnt != 3) begin
        g = exp_gnt;
        exp_bus = {cyc[g], stb[g], we[g], adr[g], sel[g], dat[g]};
        exp_ack[g] = s_ack_i;
        checks++; if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o} !== exp_bus) begin
          errors++; $display("FAIL rand_bus c%0d: got %h expected %h", c, {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o}, exp_bus);
        end
      end else begin
        checks++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin errors++; $display("FAIL rand_idle c%0d: got %b expected 00", c, {s_cyc_o, s_stb_o}); end
      end
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rand_ack c%0d: got %b expected %b", c, ack, exp_ack); end
      checks++; if (err !== 3'b000) begin errors++; $display("FAIL rand_err c%0d: got %b expected 000", c, err); end
      checks++; if (mdat !== {3{s_dat_i}}) begin errors++; $display("FAIL rand_rdata c%0d: got %h expected %h", c, mdat, {3{s_dat_i}}); end
      acked = exp_ack & cyc & stb;
      nxt_gnt = exp_gnt; nxt_last = exp_last;
      if (exp_gnt == 3) begin
        for (int i = 1; i <= 3; i++) begin
          if (nxt_gnt == 3 && cyc[(exp_last + i) % 3]) begin nxt_gnt = (exp_last + i) % 3; nxt_last = nxt_gnt; end
        end
      end else if (!cyc[exp_gnt]) begin
        nxt_gnt = 3;
      end
      @(posedge clk); #1;
      exp_gnt = nxt_gnt; exp_last = nxt_last;
      for (int n = 0; n < 3; n++) begin
        if (acked[n]) begin
          beats[n]--;
          if (beats[n] == 0) begin cyc[n] = 1'b0; stb[n] = 1'b0; end
          else begin adr[n] = $urandom; dat[n] = $urandom; we[n] = 1'($urandom); sel[n] = 4'($urandom); end
        end else if (!cyc[n] && $urandom_range(0, 3) == 0) begin
          beats[n] = int'($urandom_range(1, 3));
          cyc[n] = 1'b1; stb[n] = 1'b1;
          adr[n] = $urandom; dat[n] = $urandom; we[n] = 1'($urandom); sel[n] = 4'($urandom);
        end
      end
      s_dat_i = $urandom;
      if (exp_gnt != 3 && cyc[exp_gnt] && stb[exp_gnt]) begin
        if (lat == 0) begin s_ack_i = 1'b1; lat = int'($urandom_range(0, 3)); end
        else begin s_ack_i = 1'b0; lat--; end
      end else begin
        s_ack_i = (exp_gnt == 3) && ($urandom_range(0, 7) == 0);
      end
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_write();
    test_simultaneous();
    test_burst();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
